// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory access unit: FSM encoding,
// I/O window base and register offsets.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFFF0;
  localparam logic [3:0]  IO_OFS_LED      = 4'd0;
  localparam logic [3:0]  IO_OFS_SW       = 4'd1;

  // Exact window compare: no wrap past 16'hFFFF, IO_BASE-1 stays RAM.
  function automatic logic io_hit(input logic [15:0] addr, input logic [15:0] base);
    return (addr >= base) && ((addr - base) < 16'd16);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response handshake plus RAM port-B bus of the memory access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_address;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_write_enable;
  logic [15:0] mem_read_data;

  // master = CPU side together with the RAM model that answers port B
  modport master (
    output req_valid, req_write, req_address, req_wdata, rsp_ready, mem_read_data,
    input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_write_data, mem_write_enable
  );

  modport slave (
    input  req_valid, req_write, req_address, req_wdata, rsp_ready, mem_read_data,
    output req_ready, rsp_valid, rsp_rdata, mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/mem_access_unit_sync.sv
// Two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_access_unit.sv
// CPU load/store unit: routes word accesses to RAM port B or to a small
// memory-mapped I/O window (LED register, synchronised switches).
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter logic [15:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter int          SW_WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  mem_access_unit_if.slave    bus_if,
  input  logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] leds
);

  state_e              state_q, state_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                write_q, write_d;
  logic [SW_WIDTH-1:0] leds_q, leds_d;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                is_io;
  logic [3:0]          io_ofs;
  logic [15:0]         io_rdata;
  logic                req_ready, rsp_valid, mem_we;

  sync_2ff #(.WIDTH(SW_WIDTH)) u_sw_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d_i     (switches),
    .q_o     (sw_sync)
  );

  assign is_io  = io_hit(addr_q, IO_BASE);
  assign io_ofs = addr_q[3:0];

  always_comb begin
    io_rdata = 16'h0000;
    if (io_ofs == IO_OFS_LED) io_rdata = 16'(leds_q);
    else if (io_ofs == IO_OFS_SW) io_rdata = 16'(sw_sync);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      leds_q  <= leds_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    leds_d    = leds_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus_if.req_valid) begin
          addr_d  = bus_if.req_address;
          wdata_d = bus_if.req_wdata;
          write_d = bus_if.req_write;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Decoded from registers, so an async reset kills the strobe at once
        mem_we = write_q && !is_io;
        if (write_q) begin
          rdata_d = 16'h0000;
          if (is_io && io_ofs == IO_OFS_LED) leds_d = wdata_q[SW_WIDTH-1:0];
        end else begin
          rdata_d = is_io ? io_rdata : bus_if.mem_read_data;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus_if.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_if.req_ready        = req_ready;
  assign bus_if.rsp_valid        = rsp_valid;
  assign bus_if.rsp_rdata        = rdata_q;
  assign bus_if.mem_address      = addr_q;
  assign bus_if.mem_write_data   = wdata_q;
  assign bus_if.mem_write_enable = mem_we;
  assign leds                    = leds_q;

endmodule
